// File: rtl/sev_seg_pkg.sv
// Shared seven-segment code table (active-low, ca[6]=a ... ca[0]=g) used by both
// the display encoder and the readback decoder.
package sev_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Forward direction (Hex_To_Sev_Seg), kept on the same constants as the decoder.
  function automatic logic [6:0] hex_to_sev_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sev_seg_to_hex.sv
// Combinational decode of an active-low cathode pattern back to its hex nibble;
// flags blank and undecodable patterns.
module sev_seg_to_hex
  import sev_seg_pkg::*;
(
  input  logic [6:0] ca,
  output logic [3:0] nibble,
  output logic       valid,
  output logic       blank
);

  always_comb begin
    nibble = '0;
    valid  = 1'b1;
    blank  = 1'b0;
    case (ca)
      SEG_0: nibble = 4'h0;
      SEG_1: nibble = 4'h1;
      SEG_2: nibble = 4'h2;
      SEG_3: nibble = 4'h3;
      SEG_4: nibble = 4'h4;
      SEG_5: nibble = 4'h5;
      SEG_6: nibble = 4'h6;
      SEG_7: nibble = 4'h7;
      SEG_8: nibble = 4'h8;
      SEG_9: nibble = 4'h9;
      SEG_A: nibble = 4'hA;
      SEG_B: nibble = 4'hB;
      SEG_C: nibble = 4'hC;
      SEG_D: nibble = 4'hD;
      SEG_E: nibble = 4'hE;
      SEG_F: nibble = 4'hF;
      SEG_BLANK: begin
        valid = 1'b0;
        blank = 1'b1;
      end
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/sev_seg_capture.sv
// Readback monitor for the multiplexed seven-segment bus: captures each digit once
// its anode/cathode pattern has been stable long enough and rebuilds the value.
module sev_seg_capture
  import sev_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_DIGITS-1:0]         an,
  input  logic [6:0]                    ca,
  output logic [4*NUM_DIGITS-1:0]       value,
  output logic [NUM_DIGITS-1:0]         digit_valid,
  output logic                          frame_done,
  output logic                          error,
  output logic [$clog2(NUM_DIGITS)-1:0] err_digit
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [NUM_DIGITS-1:0] s_an;
  logic [6:0]            s_ca;
  logic [CW-1:0]         cnt;
  logic                  done;

  logic                  same;
  logic                  eligible;
  logic                  capture;
  logic [IW-1:0]         idx;
  int unsigned           zeros;
  logic [3:0]            nib;
  logic                  seg_valid;
  logic                  seg_blank;
  logic [NUM_DIGITS-1:0] base_valid;
  logic [NUM_DIGITS-1:0] next_valid;

  sev_seg_to_hex u_dec (
    .ca     (s_ca),
    .nibble (nib),
    .valid  (seg_valid),
    .blank  (seg_blank)
  );

  always_comb begin
    zeros = 0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!s_an[i]) begin
        zeros = zeros + 1;
        idx   = IW'(i);
      end
    end
    eligible = (zeros == 1);
  end

  // The port sample must still match the held sample on the capture edge, so a
  // pattern held one edge short is dropped rather than captured as it leaves.
  always_comb begin
    same       = ({an, ca} == {s_an, s_ca});
    capture    = same && eligible && (cnt == CNT_MAX) && !done;
    base_valid = frame_done ? '0 : digit_valid;
    next_valid = base_valid;
    next_valid[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_an        <= '1;
      s_ca        <= '1;
      cnt         <= '0;
      done        <= 1'b0;
      value       <= '0;
      digit_valid <= '0;
      frame_done  <= 1'b0;
      error       <= 1'b0;
      err_digit   <= '0;
    end else begin
      s_an <= an;
      s_ca <= ca;
      if (!same) begin
        cnt  <= '0;
        done <= 1'b0;
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        if (capture) done <= 1'b1;
      end

      frame_done  <= 1'b0;
      error       <= 1'b0;
      digit_valid <= base_valid;
      if (capture) begin
        if (seg_valid) begin
          value[4*int'(idx) +: 4] <= nib;
          digit_valid             <= next_valid;
          frame_done              <= &next_valid;
        end else if (!seg_blank) begin
          error     <= 1'b1;
          err_digit <= idx;
        end
      end
    end
  end

endmodule
